// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and defaults for the multi-channel clock-gating controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_WAKE = 2'd1,
    CH_ON   = 2'd2,
    CH_IDLE = 2'd3
  } ch_state_e;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_IDLE_W   = 8;
  localparam int DEF_WAKE_LAT = 2;

  // Wake counter only has to hold WAKE_LAT-1; keep at least one bit.
  function automatic int wcnt_width(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/clk_gate_ch.sv
// One gated-clock channel: wake/idle FSM, its counters and a glitch-free gate.
module clk_gate_ch
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_W   = DEF_IDLE_W,
  parameter int WAKE_LAT = DEF_WAKE_LAT,
  parameter bit RST_ON   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_en_i,
  input  logic              auto_en_i,
  input  logic              req_i,
  input  logic              busy_i,
  input  logic [IDLE_W-1:0] idle_thr_i,
  output logic              clk_o,
  output logic              ack_o,
  output logic [1:0]        state_o
);

  localparam int WCW = wcnt_width(WAKE_LAT);
  localparam logic [WCW-1:0]    WCNT_INIT = WCW'(WAKE_LAT - 1);
  localparam logic [WCW-1:0]    WCNT_ONE  = WCW'(1);
  localparam logic [IDLE_W-1:0] ICNT_ONE  = IDLE_W'(1);
  localparam ch_state_e         RST_STATE = RST_ON ? CH_ON : CH_OFF;

  ch_state_e         state_q, state_d;
  logic              en_q, en_d;
  logic              ack_q, ack_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [IDLE_W-1:0] icnt_q, icnt_d;
  logic              gate_en_q, gate_en_d;
  logic              wake;

  // Anything that needs the clock: a request, pending work, or auto gating off.
  assign wake = req_i | busy_i | ~auto_en_i;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    ack_d   = ack_q;
    wcnt_d  = wcnt_q;
    icnt_d  = icnt_q;
    case (state_q)
      CH_OFF: begin
        if (wake) begin
          state_d = CH_WAKE;
          en_d    = 1'b1;
          wcnt_d  = WCNT_INIT;
        end
      end
      CH_WAKE: begin
        if (wcnt_q == '0) begin
          state_d = CH_ON;
          ack_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WCNT_ONE;
        end
      end
      CH_ON: begin
        if (!wake) begin
          if (idle_thr_i == '0) begin
            state_d = CH_OFF;
            en_d    = 1'b0;
            ack_d   = 1'b0;
          end else begin
            state_d = CH_IDLE;
            icnt_d  = idle_thr_i - ICNT_ONE;
          end
        end
      end
      CH_IDLE: begin
        if (wake) begin
          state_d = CH_ON;
        end else if (icnt_q == '0) begin
          state_d = CH_OFF;
          en_d    = 1'b0;
          ack_d   = 1'b0;
        end else begin
          icnt_d = icnt_q - ICNT_ONE;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      en_q    <= RST_ON;
      ack_q   <= RST_ON;
      wcnt_q  <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
    end
  end

  // Gate enable is captured while clk_i is low, so clk_o never sees a runt pulse.
  always_comb gate_en_d = en_q | test_en_i;

  always_ff @(negedge clk_i) begin
    gate_en_q <= gate_en_d;
  end

  assign clk_o   = clk_i & gate_en_q;
  assign ack_o   = ack_q;
  assign state_o = state_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: NUM_CH independent gated clocks from clk_i.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int                IDLE_W   = DEF_IDLE_W,
  parameter int                NUM_CH   = DEF_NUM_CH,
  parameter int                WAKE_LAT = DEF_WAKE_LAT,
  parameter logic [NUM_CH-1:0] RST_ON   = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                test_en_i,
  input  logic [NUM_CH-1:0]   auto_en_i,
  input  logic [NUM_CH-1:0]   req_i,
  input  logic [NUM_CH-1:0]   busy_i,
  input  logic [IDLE_W-1:0]   idle_thr_i,
  output logic [NUM_CH-1:0]   clk_o,
  output logic [NUM_CH-1:0]   ack_o,
  output logic [2*NUM_CH-1:0] state_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gate_ch #(
      .IDLE_W   (IDLE_W),
      .WAKE_LAT (WAKE_LAT),
      .RST_ON   (RST_ON[i])
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .test_en_i  (test_en_i),
      .auto_en_i  (auto_en_i[i]),
      .req_i      (req_i[i]),
      .busy_i     (busy_i[i]),
      .idle_thr_i (idle_thr_i),
      .clk_o      (clk_o[i]),
      .ack_o      (ack_o[i]),
      .state_o    (state_o[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed vector table plus randomized run against a timeline model.
module tb_clk_gate_ctrl;

  localparam int NCH = 4;
  localparam int WL  = 2;
  localparam logic [NCH-1:0] RST_ON_P = 4'b0101;

  logic           clk;
  logic           rst;
  logic           test_en;
  logic [NCH-1:0] auto_en;
  logic [NCH-1:0] req;
  logic [NCH-1:0] busy;
  logic [7:0]     thr;
  logic [NCH-1:0] clk_o;
  logic [NCH-1:0] ack_o;
  logic [2*NCH-1:0] state_o;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  clk_gate_ctrl #(
    .IDLE_W   (8),
    .NUM_CH   (NCH),
    .WAKE_LAT (WL),
    .RST_ON   (RST_ON_P)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .test_en_i  (test_en),
    .auto_en_i  (auto_en),
    .req_i      (req),
    .busy_i     (busy),
    .idle_thr_i (thr),
    .clk_o      (clk_o),
    .ack_o      (ack_o),
    .state_o    (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Per channel: clock enabled, acknowledged, edges left until ack,
  // and inactive edges left before gating (0 = not counting down).
  int m_en[NCH], m_ack[NCH], m_wake_left[NCH], m_idle_left[NCH];
  bit m_known = 1'b0;

  function automatic logic [7:0] model_state();
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m_en[i] == 0)            s[2*i +: 2] = 2'd0;
      else if (m_ack[i] == 0)      s[2*i +: 2] = 2'd1;
      else if (m_idle_left[i] > 0) s[2*i +: 2] = 2'd3;
      else                         s[2*i +: 2] = 2'd2;
    end
    return s;
  endfunction

  function automatic logic [3:0] model_ack();
    logic [3:0] a;
    for (int i = 0; i < NCH; i++) a[i] = (m_ack[i] != 0);
    return a;
  endfunction

  task automatic model_edge();
    bit active;
    for (int i = 0; i < NCH; i++) begin
      active = req[i] | busy[i] | ~auto_en[i];
      if (rst) begin
        m_en[i] = RST_ON_P[i]; m_ack[i] = RST_ON_P[i];
        m_wake_left[i] = 0; m_idle_left[i] = 0;
      end else if (m_en[i] == 0) begin
        if (active) begin m_en[i] = 1; m_wake_left[i] = WL; end
      end else if (m_ack[i] == 0) begin
        m_wake_left[i]--;
        if (m_wake_left[i] == 0) m_ack[i] = 1;
      end else if (m_idle_left[i] == 0) begin
        if (!active) begin
          if (thr == 0) begin m_en[i] = 0; m_ack[i] = 0; end
          else m_idle_left[i] = int'(thr);
        end
      end else begin
        if (active) m_idle_left[i] = 0;
        else begin
          m_idle_left[i]--;
          if (m_idle_left[i] == 0) begin m_en[i] = 0; m_ack[i] = 0; end
        end
      end
    end
    m_known = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, step_no, act, exp);
    end
  endtask

  // One clock edge: outputs are sampled 1 time unit after the rising edge,
  // inputs are then changed well before the following falling edge.
  task automatic step();
    logic [3:0] exp_clk;
    bit         clk_valid;
    clk_valid = m_known;
    for (int i = 0; i < NCH; i++) exp_clk[i] = (m_en[i] != 0) | test_en;
    model_edge();
    exp_q.push_back(model_state());
    exp_q.push_back({4'h0, model_ack()});
    @(posedge clk);
    #1;
    check("state_o", state_o, exp_q.pop_front());
    check("ack_o", {4'h0, ack_o}, exp_q.pop_front());
    if (clk_valid) check("clk_o_high_phase", {4'h0, clk_o}, {4'h0, exp_clk});
    step_no++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       te;
    logic [3:0] auto_en;
    logic [3:0] req;
    logic [3:0] busy;
    logic [7:0] thr;
    logic [7:0] exp_state;
    logic [3:0] exp_ack;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic r, input logic te, input logic [3:0] a,
                              input logic [3:0] q, input logic [3:0] b, input logic [7:0] t,
                              input logic [7:0] s, input logic [3:0] k);
    vec_t v;
    v.rst = r; v.te = te; v.auto_en = a; v.req = q; v.busy = b; v.thr = t;
    v.exp_state = s; v.exp_ack = k;
    return v;
  endfunction

  // ---------------- driver / test sequence ----------------
  initial begin
    rst = 1'b1; test_en = 1'b0; auto_en = '1; req = '0; busy = '0; thr = 8'd4;
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_ack[i] = 0; m_wake_left[i] = 0; m_idle_left[i] = 0;
    end

    //                 rst te  auto  req   busy  thr    state  ack
    tbl[0]  = mk(1, 0, 4'hF, 4'h0, 4'h0, 8'd4, 8'h22, 4'h5); // reset: ch0,ch2 ON
    tbl[1]  = mk(0, 0, 4'hF, 4'h2, 4'h5, 8'd4, 8'h26, 4'h5); // ch1 wakes
    tbl[2]  = mk(0, 0, 4'hF, 4'h0, 4'h5, 8'd4, 8'h26, 4'h5); // req dropped, wake continues
    tbl[3]  = mk(0, 0, 4'hF, 4'h0, 4'h5, 8'd4, 8'h2A, 4'h7); // ch1 acked WAKE_LAT edges after en
    tbl[4]  = mk(0, 0, 4'hF, 4'h0, 4'h4, 8'd4, 8'h2F, 4'h7); // ch0,ch1 idle
    tbl[5]  = mk(0, 0, 4'hF, 4'h0, 4'h4, 8'd4, 8'h2F, 4'h7);
    tbl[6]  = mk(0, 0, 4'hF, 4'h0, 4'h6, 8'd4, 8'h2B, 4'h7); // ch1 busy on 3rd idle cycle
    tbl[7]  = mk(0, 0, 4'hF, 4'h0, 4'h4, 8'd4, 8'h2F, 4'h7);
    tbl[8]  = mk(0, 0, 4'hF, 4'h0, 4'h4, 8'd4, 8'h2C, 4'h6); // ch0 gated
    tbl[9]  = mk(0, 0, 4'hF, 4'h0, 4'h4, 8'd4, 8'h2C, 4'h6);
    tbl[10] = mk(0, 0, 4'hF, 4'h0, 4'h4, 8'd4, 8'h2C, 4'h6);
    tbl[11] = mk(0, 0, 4'hF, 4'h0, 4'h4, 8'd4, 8'h20, 4'h4); // ch1 full 4-cycle idle
    tbl[12] = mk(0, 0, 4'hF, 4'h0, 4'h0, 8'd0, 8'h00, 4'h0); // thr=0: ch2 gates at once
    tbl[13] = mk(0, 0, 4'hE, 4'h0, 4'h0, 8'd0, 8'h01, 4'h0); // auto off wakes ch0
    tbl[14] = mk(0, 0, 4'hE, 4'h0, 4'h0, 8'd0, 8'h01, 4'h0);
    tbl[15] = mk(0, 0, 4'hE, 4'h0, 4'h0, 8'd0, 8'h02, 4'h1);
    tbl[16] = mk(0, 0, 4'hE, 4'h0, 4'h0, 8'd0, 8'h02, 4'h1); // never gates while forced
    tbl[17] = mk(0, 1, 4'hE, 4'h0, 4'h0, 8'd0, 8'h02, 4'h1);
    tbl[18] = mk(0, 1, 4'hF, 4'h0, 4'h0, 8'd0, 8'h00, 4'h0);
    tbl[19] = mk(0, 1, 4'hF, 4'h0, 4'h0, 8'd0, 8'h00, 4'h0); // test_en, all OFF
    tbl[20] = mk(0, 0, 4'hF, 4'h0, 4'h0, 8'd0, 8'h00, 4'h0);
    tbl[21] = mk(0, 0, 4'hF, 4'hB, 4'h0, 8'd0, 8'h45, 4'h0); // ch0,1,3 in WAKE
    tbl[22] = mk(1, 0, 4'hF, 4'h0, 4'h0, 8'd0, 8'h22, 4'h5); // reset mid-WAKE
    tbl[23] = mk(0, 0, 4'hF, 4'h0, 4'h0, 8'd3, 8'h33, 4'h5); // ch0,ch2 IDLE icnt=2
    tbl[24] = mk(1, 0, 4'hF, 4'h0, 4'h0, 8'd3, 8'h22, 4'h5); // reset mid-IDLE
    tbl[25] = mk(0, 0, 4'hF, 4'h2, 4'h5, 8'd3, 8'h26, 4'h5);
    tbl[26] = mk(0, 0, 4'hF, 4'h0, 4'h5, 8'd3, 8'h26, 4'h5);
    tbl[27] = mk(0, 0, 4'hF, 4'h0, 4'h5, 8'd3, 8'h2A, 4'h7);
    tbl[28] = mk(0, 0, 4'hF, 4'h0, 4'h5, 8'd3, 8'h2E, 4'h7); // ch1 IDLE icnt=2
    tbl[29] = mk(1, 0, 4'hF, 4'h0, 4'h5, 8'd3, 8'h22, 4'h5); // reset: ch1 back OFF

    // Let the first falling edge pass so inputs are stable before edge 1.
    #2;
    for (int v = 0; v < NV; v++) begin
      rst = tbl[v].rst; test_en = tbl[v].te; auto_en = tbl[v].auto_en;
      req = tbl[v].req; busy = tbl[v].busy; thr = tbl[v].thr;
      step();
      check("vec_state", state_o, tbl[v].exp_state);
      check("vec_ack", {4'h0, ack_o}, {4'h0, tbl[v].exp_ack});
    end

    // Hand sequence: a gated channel's clock stays low through a whole period.
    rst = 1'b0; test_en = 1'b0; auto_en = 4'hF; req = 4'h0; busy = 4'h5; thr = 8'd2;
    step();
    @(negedge clk); #2;
    check("clk_o_low_phase", {4'h0, clk_o}, 8'h00);
    @(posedge clk); #1;
    step_no++;
    // That idle edge was taken without the model; resynchronise with a reset.
    rst = 1'b1;
    step();

    // Randomized phase.
    for (int n = 0; n < 500; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      test_en = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NCH; i++) begin
        auto_en[i] = ($urandom_range(0, 7) != 0);
        req[i]     = ($urandom_range(0, 7) == 0);
        busy[i]    = ($urandom_range(0, 5) == 0);
      end
      thr = 8'($urandom_range(0, 5));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
